// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arbitrated output mux.
package arb_pkg;

    // Arbitration policy selectors for the RR_MODE parameter
    localparam int FIXED = 0;
    localparam int RR    = 1;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks one requester, round-robin after last_grant
// or fixed lowest-index priority.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = RR,
    parameter int IDX_W   = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_any
);

    localparam int unsigned NCH = NUM_CH;

    logic [31:0] start;

    // First scan position: one past last_grant with explicit wrap, or 0
    always_comb begin
        start = '0;
        if (RR_MODE == RR) begin
            if (32'(last_grant) >= NCH - 1)
                start = '0;
            else
                start = 32'(last_grant) + 32'd1;
        end
    end

    // Walk the request vector from start, wrapping, first set bit wins
    always_comb begin
        logic [31:0]      pos;
        logic [IDX_W-1:0] pos_idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = '0;
        pos_idx   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            pos = start + 32'(k);
            if (pos >= NCH)
                pos = pos - NCH;
            pos_idx = pos[IDX_W-1:0];
            if (!grant_any && req[pos_idx]) begin
                grant_any      = 1'b1;
                grant_idx      = pos_idx;
                grant[pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel handshaked arbitrated mux with a one-deep registered output.
module rr_arb_mux
    import arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = RR
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CH-1:0]               in_valid,
    input  logic [NUM_CH*WIDTH-1:0]         in_data,
    output logic [NUM_CH-1:0]               in_ready,
    output logic                            out_valid,
    output logic [WIDTH-1:0]                out_data,
    output logic [clog2_min1(NUM_CH)-1:0]   out_ch,
    input  logic                            out_ready
);

    localparam int          IDX_W = clog2_min1(NUM_CH);
    localparam int unsigned NCH   = NUM_CH;

    logic [IDX_W-1:0]  last_grant;
    logic [NUM_CH-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_any;
    logic              load;
    logic              accept;
    logic [WIDTH-1:0]  sel_data;

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE),
        .IDX_W   (IDX_W)
    ) u_arbiter (
        .req        (in_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    // Handshake: output register free this cycle, and nothing accepted in reset
    always_comb begin
        load     = !out_valid || out_ready;
        accept   = grant_any && load && !reset;
        in_ready = (load && !reset) ? grant : '0;
    end

    // Select the winning channel's data from the one-hot grant
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant[i])
                sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= IDX_W'(NCH - 1);
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant_idx;
            if (RR_MODE == RR)
                last_grant <= grant_idx;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench: a round-robin and a fixed-priority instance share
// stimulus and are compared every cycle against a behavioural model.
module tb_rr_arb_mux;
    import arb_pkg::*;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic           out_ready;

    logic [N-1:0] rr_in_ready, fx_in_ready;
    logic         rr_out_valid, fx_out_valid;
    logic [W-1:0] rr_out_data, fx_out_data;
    logic [1:0]   rr_out_ch, fx_out_ch;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(W), .NUM_CH(N), .RR_MODE(RR)) dut_rr (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
        .out_ch(rr_out_ch), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(W), .NUM_CH(N), .RR_MODE(FIXED)) dut_fx (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fx_in_ready), .out_valid(fx_out_valid), .out_data(fx_out_data),
        .out_ch(fx_out_ch), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = RR, 1 = fixed) -----------
    logic         m_valid[2];
    logic [W-1:0] m_data[2];
    int           m_ch[2];
    int           m_last[2];

    function automatic int winner(input int m, input int last, input logic [N-1:0] v);
        if (m == 0) begin
            for (int k = 1; k <= N; k++)
                if (v[(last + k) % N]) return (last + k) % N;
        end else begin
            for (int i = 0; i < N; i++)
                if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int m);
        int w;
        if (reset) return '0;
        if (m_valid[m] && !out_ready) return '0;
        w = winner(m, m_last[m], in_valid);
        if (w < 0) return '0;
        return N'(1) << w;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int w;
            w = winner(m, m_last[m], in_valid);
            if (reset) begin
                m_valid[m] <= 1'b0;
                m_data[m]  <= '0;
                m_ch[m]    <= 0;
                m_last[m]  <= N - 1;
            end else if (!m_valid[m] || out_ready) begin
                if (w >= 0) begin
                    m_valid[m] <= 1'b1;
                    m_data[m]  <= in_data[w*W +: W];
                    m_ch[m]    <= w;
                    if (m == 0) m_last[m] <= w;
                end else begin
                    m_valid[m] <= 1'b0;
                end
            end
        end
    end

    // Single compare process against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rr_in_ready",  32'(rr_in_ready),  32'(exp_ready(0)));
            chk("rr_out_valid", 32'(rr_out_valid), 32'(m_valid[0]));
            chk("rr_out_data",  rr_out_data,       m_data[0]);
            chk("rr_out_ch",    32'(rr_out_ch),    32'(m_ch[0]));
            chk("fx_in_ready",  32'(fx_in_ready),  32'(exp_ready(1)));
            chk("fx_out_valid", 32'(fx_out_valid), 32'(m_valid[1]));
            chk("fx_out_data",  fx_out_data,       m_data[1]);
            chk("fx_out_ch",    32'(fx_out_ch),    32'(m_ch[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------------------
    initial begin
        logic [1:0]  seq_ch[5];
        logic [31:0] seq_d[5];
        logic [1:0]  ws_ch[3];
        seq_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        seq_d  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
        ws_ch  = '{2'd1, 2'd3, 2'd1};

        reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset then idle
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid", 32'(rr_out_valid), 32'd0);
            chk("idle_data",  rr_out_data, 32'd0);
            chk("idle_ch",    32'(rr_out_ch), 32'd0);
            chk("idle_ready", 32'(rr_in_ready), 32'd0);
            tick();
        end

        // Round-robin fairness
        in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        in_valid = 4'b1111;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("fair_ch",   32'(rr_out_ch), 32'(seq_ch[k]));
            chk("fair_data", rr_out_data, seq_d[k]);
            chk("fair_fx_ch", 32'(fx_out_ch), 32'd0);
            if (k < 4) @(posedge clk);
        end
        tick();

        // Backpressure
        in_valid = '0; tick();
        in_data = '0; in_data[2*W +: W] = 32'hDEADBEEF;
        in_valid = 4'b0100; out_ready = 1'b0;
        @(negedge clk);
        chk("bp_accept_ready", 32'(rr_in_ready), 32'b0100);
        tick();
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 32'(rr_out_valid), 32'd1);
            chk("bp_data",  rr_out_data, 32'hDEADBEEF);
            chk("bp_ready", 32'(rr_in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(rr_in_ready), 32'b0100);
        tick();

        // Wrap and skip: prime last_grant=3, then ch1 and ch3 alternate
        in_valid = 4'b1000;
        tick();
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("wrap_ch", 32'(rr_out_ch), 32'(ws_ch[k]));
        end

        // Fixed priority: ch1 always beats ch3
        repeat (4) begin
            @(negedge clk);
            chk("fixed_ch",    32'(fx_out_ch), 32'd1);
            chk("fixed_ready", 32'(fx_in_ready), 32'b0010);
            @(posedge clk);
        end
        #1;

        // Reset mid-stall
        in_valid = '0; tick();
        in_data[1*W +: W] = 32'h11111111;
        in_valid = 4'b0010; out_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_stall_valid", 32'(rr_out_valid), 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cycle_ready_rr", 32'(rr_in_ready), 32'd0);
        chk("rst_cycle_ready_fx", 32'(fx_in_ready), 32'd0);
        tick();
        reset = 1'b0; in_valid = 4'b1010; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_after_valid", 32'(rr_out_valid), 32'd0);
        chk("rst_after_data",  rr_out_data, 32'd0);
        chk("rst_after_ready", 32'(rr_in_ready), 32'b0010);
        tick();
        @(negedge clk);
        chk("rst_first_grant", 32'(rr_out_ch), 32'd1);
        tick();

        // Randomised traffic checked by the model each cycle
        repeat (2000) begin
            reset     = ($urandom_range(63) == 0);
            in_valid  = N'($urandom);
            for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
            out_ready = ($urandom_range(9) < 7);
            tick();
        end

        reset = 1'b0; in_valid = '0;
        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
